// File: rtl/gobou_ctrl_mac.sv
// gobou FC datapath: MAC control stage. Counts input beats into dot products,
// drives accumulator enables and emits the dot-product stream to the bias stage.
// Optional macro GOBOU_MAC_CNT_EN adds the dp_cnt output (dot products since out start).
module gobou_ctrl_mac #(
  parameter int unsigned D_MAC     = 2,
  parameter int unsigned SIZEWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 in_ctrl_start,
  input  logic                 in_ctrl_valid,
  input  logic                 in_ctrl_stop,
  input  logic [SIZEWIDTH-1:0] in_size,
  output logic                 out_ctrl_start,
  output logic                 out_ctrl_valid,
  output logic                 out_ctrl_stop,
  output logic                 accum_clear,
  output logic                 accum_we,
  output logic                 err_partial
`ifdef GOBOU_MAC_CNT_EN
  ,
  output logic [SIZEWIDTH-1:0] dp_cnt
`endif
);

  localparam int unsigned NST = D_MAC + 1;
  localparam int unsigned DCW = (D_MAC < 2) ? 1 : $clog2(D_MAC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SIZEWIDTH-1:0] cnt_q, cnt_d;
  logic [SIZEWIDTH-1:0] size_q, size_d;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic                 err_d;

  logic tag_start, tag_valid, tag_first, tag_last, tag_stop;

  // Delay line; valid/first lines end where the accumulator consumes them.
  logic [NST-1:0]   st_start;
  logic [NST-1:0]   st_vlast;
  logic [NST-1:0]   st_stop;
  logic [D_MAC-1:0] st_valid;
  logic [D_MAC-1:0] st_vfirst;

  // Next-state, beat tagging and sticky error update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    dcnt_d    = dcnt_q;
    err_d     = err_partial;
    tag_start = 1'b0;
    tag_valid = 1'b0;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    tag_stop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_ctrl_start) begin
          state_d   = ACC;
          size_d    = (in_size == '0) ? SIZEWIDTH'(1) : in_size;
          cnt_d     = '0;
          err_d     = 1'b0;
          tag_start = 1'b1;
        end
      end
      ACC: begin
        if (in_ctrl_valid) begin
          tag_valid = 1'b1;
          tag_first = (cnt_q == '0);
          tag_last  = (cnt_q == SIZEWIDTH'(size_q - SIZEWIDTH'(1)));
          cnt_d     = tag_last ? '0 : SIZEWIDTH'(cnt_q + SIZEWIDTH'(1));
        end
        if (in_ctrl_stop) begin
          tag_stop = 1'b1;
          state_d  = DRAIN;
          dcnt_d   = '0;
          if (cnt_d != '0) begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Hold off new starts until the delay line has emptied
        if (dcnt_q == DCW'(D_MAC)) begin
          state_d = IDLE;
        end else begin
          dcnt_d = DCW'(dcnt_q + DCW'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      dcnt_q      <= '0;
      err_partial <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      dcnt_q      <= dcnt_d;
      err_partial <= err_d;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      st_start  <= '0;
      st_vlast  <= '0;
      st_stop   <= '0;
      st_valid  <= '0;
      st_vfirst <= '0;
    end else begin
      st_start  <= (st_start << 1) | NST'(tag_start);
      st_vlast  <= (st_vlast << 1) | NST'(tag_valid & tag_last);
      st_stop   <= (st_stop << 1) | NST'(tag_stop);
      st_valid  <= (st_valid << 1) | D_MAC'(tag_valid);
      st_vfirst <= (st_vfirst << 1) | D_MAC'(tag_valid & tag_first);
    end
  end

  assign accum_we       = st_valid[D_MAC-1];
  assign accum_clear    = st_vfirst[D_MAC-1];
  assign out_ctrl_start = st_start[D_MAC];
  assign out_ctrl_valid = st_vlast[D_MAC];
  assign out_ctrl_stop  = st_stop[D_MAC];

`ifdef GOBOU_MAC_CNT_EN
  // Looks one stage ahead so the clear lands with out_ctrl_start
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      dp_cnt <= '0;
    end else if (st_start[D_MAC-1]) begin
      dp_cnt <= '0;
    end else if (st_vlast[D_MAC-1]) begin
      dp_cnt <= SIZEWIDTH'(dp_cnt + SIZEWIDTH'(1));
    end
  end
`endif

endmodule

// File: tb/tb_gobou_ctrl_mac.sv
// Bench for gobou_ctrl_mac: directed scenarios plus random control traffic checked
// every cycle against a cycle-indexed expectation model.
module tb_gobou_ctrl_mac;
  localparam int unsigned D  = 2;
  localparam int unsigned SW = 16;
  localparam int NC = 8192;

  logic          clk = 1'b0;
  logic          xrst;
  logic          in_ctrl_start, in_ctrl_valid, in_ctrl_stop;
  logic [SW-1:0] in_size;
  logic          out_ctrl_start, out_ctrl_valid, out_ctrl_stop;
  logic          accum_clear, accum_we, err_partial;
`ifdef GOBOU_MAC_CNT_EN
  logic [SW-1:0] dp_cnt;
`endif

  gobou_ctrl_mac #(.D_MAC(D), .SIZEWIDTH(SW)) dut (
`ifdef GOBOU_MAC_CNT_EN
    .dp_cnt         (dp_cnt),
`endif
    .clk            (clk),
    .xrst           (xrst),
    .in_ctrl_start  (in_ctrl_start),
    .in_ctrl_valid  (in_ctrl_valid),
    .in_ctrl_stop   (in_ctrl_stop),
    .in_size        (in_size),
    .out_ctrl_start (out_ctrl_start),
    .out_ctrl_valid (out_ctrl_valid),
    .out_ctrl_stop  (out_ctrl_stop),
    .accum_clear    (accum_clear),
    .accum_we       (accum_we),
    .err_partial    (err_partial)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output value per cycle index
  bit exp_we[NC], exp_clr[NC], exp_ost[NC], exp_ov[NC], exp_osp[NC], exp_err[NC];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rst_cnt = 0;

  // Model state: 0 idle, 1 accumulating, 2 draining
  int mode = 0;
  int mcnt = 0;
  int msize = 1;
  int idle_at = 0;
  bit merr = 1'b0;

  int q_clr[$], q_ov[$], q_ost[$], q_osp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                     input int c);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, c);
    end
  endtask

  // Drive one cycle of inputs and project their effect onto future outputs
  task automatic step(input bit s, input bit v, input bit p, input int sz);
    int k;
    @(negedge clk);
    k = cyc;
    if (k + D + 2 >= NC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", k, NC - D - 2);
      $fatal(1);
    end
    in_ctrl_start = s;
    in_ctrl_valid = v;
    in_ctrl_stop  = p;
    in_size       = SW'(sz);
    if (mode == 2 && k >= idle_at) mode = 0;
    if (mode == 0) begin
      if (s) begin
        msize = (sz % 65536 == 0) ? 1 : sz % 65536;
        mcnt  = 0;
        merr  = 1'b0;
        exp_ost[k+D+1] = 1'b1;
        mode  = 1;
      end
    end else if (mode == 1) begin
      if (v) begin
        exp_we[k+D]  = 1'b1;
        exp_clr[k+D] = (mcnt == 0);
        if (mcnt == msize - 1) exp_ov[k+D+1] = 1'b1;
        mcnt = (mcnt + 1) % msize;
      end
      if (p) begin
        exp_osp[k+D+1] = 1'b1;
        if (mcnt != 0) merr = 1'b1;
        mode    = 2;
        idle_at = k + D + 2;
      end
    end
    exp_err[k+1] = merr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    int k;
    step(1'b0, 1'b0, 1'b0, 0);
    k = cyc;
    #2;
    xrst = 1'b0;
    for (int i = k + 1; i < NC; i++) begin
      exp_we[i] = 0; exp_clr[i] = 0; exp_ost[i] = 0;
      exp_ov[i] = 0; exp_osp[i] = 0; exp_err[i] = 0;
    end
    mode = 0; mcnt = 0; merr = 1'b0;
    rst_cnt++;
    #1;
    chk("async_rst_accum_we", accum_we, 0, k);
    chk("async_rst_accum_clear", accum_clear, 0, k);
    chk("async_rst_out_valid", out_ctrl_valid, 0, k);
    chk("async_rst_out_start", out_ctrl_start, 0, k);
    chk("async_rst_out_stop", out_ctrl_stop, 0, k);
    chk("async_rst_err", err_partial, 0, k);
    @(posedge clk);
    #3;
    xrst = 1'b1;
  endtask

  // Per-cycle compare of every output against the model
`ifdef GOBOU_MAC_CNT_EN
  int exp_dp = 0;
  int rst_seen = 0;
`endif
  always @(posedge clk) begin
    int c;
    #4;
    if (chk_en) begin
      c = cyc;
      chk("accum_we", accum_we, exp_we[c], c);
      chk("accum_clear", accum_clear, exp_clr[c], c);
      chk("out_ctrl_start", out_ctrl_start, exp_ost[c], c);
      chk("out_ctrl_valid", out_ctrl_valid, exp_ov[c], c);
      chk("out_ctrl_stop", out_ctrl_stop, exp_osp[c], c);
      chk("err_partial", err_partial, exp_err[c], c);
`ifdef GOBOU_MAC_CNT_EN
      if (rst_seen != rst_cnt) begin
        exp_dp = 0;
        rst_seen = rst_cnt;
      end
      if (exp_ost[c]) exp_dp = 0;
      if (exp_ov[c]) exp_dp = (exp_dp + 1) % 65536;
      chk("dp_cnt", dp_cnt, exp_dp, c);
`endif
      if (accum_clear) q_clr.push_back(c);
      if (out_ctrl_valid) q_ov.push_back(c);
      if (out_ctrl_start) q_ost.push_back(c);
      if (out_ctrl_stop) q_osp.push_back(c);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by time 500000");
    $fatal(1);
  end

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    int b0, tstop;
    xrst = 1'b0;
    in_ctrl_start = 0; in_ctrl_valid = 0; in_ctrl_stop = 0; in_size = '0;
    #2;
    chk("rst_accum_we", accum_we, 0, 0);
    chk("rst_accum_clear", accum_clear, 0, 0);
    chk("rst_out_start", out_ctrl_start, 0, 0);
    chk("rst_out_valid", out_ctrl_valid, 0, 0);
    chk("rst_out_stop", out_ctrl_stop, 0, 0);
    chk("rst_err", err_partial, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    xrst = 1'b1;
    chk_en = 1'b1;

    // Reset in the middle of accumulation; no stop may follow
    step(1, 0, 0, 4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("pre_rst_accum_we", accum_we, 1, cyc);
    q_osp.delete();
    do_reset();
    idle(6);
    chk("rst_no_stop", q_osp.size(), 0, cyc);

    // size 4, 8 back-to-back beats
    q_clr.delete(); q_ov.delete(); q_osp.delete();
    step(1, 0, 0, 4);
    step(0, 1, 0, 0);
    b0 = cyc;
    for (int i = 1; i < 8; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    tstop = cyc;
    idle(6);
    chk("s4_clr_count", q_clr.size(), 2, cyc);
    chk("s4_clr0_cycle", qat(q_clr, 0), b0 + 2, cyc);
    chk("s4_clr1_cycle", qat(q_clr, 1), b0 + 6, cyc);
    chk("s4_ov_count", q_ov.size(), 2, cyc);
    chk("s4_ov0_cycle", qat(q_ov, 0), b0 + 6, cyc);
    chk("s4_ov1_cycle", qat(q_ov, 1), b0 + 10, cyc);
    chk("s4_stop_cycle", qat(q_osp, 0), tstop + 3, cyc);
    chk("s4_err", err_partial, 0, cyc);
`ifdef GOBOU_MAC_CNT_EN
    chk("s4_dp_cnt", dp_cnt, 2, cyc);
`endif

    // size 1 with idle gaps of 0, 2, 1, 0 between beats
    q_clr.delete(); q_ov.delete();
    step(1, 0, 0, 1);
    step(0, 1, 0, 0);
    b0 = cyc;
    step(0, 1, 0, 0);
    idle(2);
    step(0, 1, 0, 0);
    idle(1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(6);
    chk("s1_ov_count", q_ov.size(), 5, cyc);
    chk("s1_ov0_cycle", qat(q_ov, 0), b0 + 3, cyc);
    chk("s1_ov2_cycle", qat(q_ov, 2), b0 + 7, cyc);
    chk("s1_clr_count", q_clr.size(), 5, cyc);

    // size 0 behaves as size 1
    q_ov.delete();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(6);
    chk("s0_ov_count", q_ov.size(), 3, cyc);

    // size 3, stop coincident with 5th beat leaves a partial product
    q_ov.delete();
    step(1, 0, 0, 3);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    idle(8);
    chk("s3_ov_count", q_ov.size(), 1, cyc);
    chk("s3_err", err_partial, 1, cyc);

    // Starts during ACC and DRAIN are ignored
    q_ov.delete(); q_ost.delete();
    step(1, 0, 0, 2);
    step(0, 1, 0, 0);
    chk("restart_err_clear", err_partial, 0, cyc);
    step(1, 1, 0, 5);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 7);
    idle(8);
    chk("ign_ost_count", q_ost.size(), 1, cyc);
    chk("ign_ov_count", q_ov.size(), 2, cyc);
    chk("ign_err", err_partial, 0, cyc);

    // Random control traffic with occasional asynchronous resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 65,
             $urandom_range(0, 99) < 5,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                         : int'($urandom_range(0, 5)));
      end
    end
    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
